// File: rtl/step_pkg.sv
// Shared types for the step sequencer: FSM states, pulse-generator speed modes
// and the segment record held in the program table.
package step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SLOW    = 2'b00;
  localparam mode_t MODE_MED     = 2'b01;
  localparam mode_t MODE_FAST    = 2'b10;
  localparam mode_t MODE_PROFILE = 2'b11;

  // Widest step count any instance may use; narrower instances zero-extend.
  localparam int STEP_W_MAX = 32;

  typedef struct packed {
    mode_t                 mode;
    logic [STEP_W_MAX-1:0] steps;
  } seg_t;

endpackage

// File: rtl/step_seq_table.sv
// Segment program table: NUM_SEG records, one synchronous write port and one
// asynchronous read port. Deliberately not reset so a program survives RESET.
module step_seq_table
  import step_pkg::*;
#(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = $clog2(NUM_SEG)
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [SEG_W-1:0] wr_addr,
  input  seg_t             wr_data,
  input  logic [SEG_W-1:0] rd_addr,
  output seg_t             rd_data
);

  seg_t mem [NUM_SEG];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/step_sequencer.sv
// Segment-program controller: walks the table, drives Start/Mode of the pulse
// generator and counts returned Pulse rising edges per segment.
module step_sequencer
  import step_pkg::*;
#(
  parameter int NUM_SEG    = 8,
  parameter int STEP_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       WrEn,
  input  logic [$clog2(NUM_SEG)-1:0] WrAddr,
  input  logic [1:0]                 WrMode,
  input  logic [STEP_W-1:0]          WrSteps,
  input  logic                       Go,
  input  logic                       Abort,
  input  logic                       Pulse,
  output logic                       Start,
  output logic [1:0]                 Mode,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(NUM_SEG)-1:0] SegIdx,
  output logic [STEP_W-1:0]          StepCount
);

  localparam int SEG_W = $clog2(NUM_SEG);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_reg;
  logic [SEG_W-1:0]   seg_idx_reg;
  logic [STEP_W-1:0]  step_count_reg;
  logic [STEP_W-1:0]  target_reg;
  mode_t              mode_reg;
  logic               start_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               pulse_q_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;

  seg_t               wr_seg;
  seg_t               rd_seg;
  logic               table_wr_en;
  logic               pulse_rise;
  logic [STEP_W-1:0]  step_count_next;

  // The table is only writable while idle so a running program cannot change.
  assign table_wr_en     = WrEn && (state_reg == ST_IDLE);
  assign pulse_rise      = Pulse && !pulse_q_reg;
  assign step_count_next = step_count_reg + STEP_W'(1);

  always_comb begin
    wr_seg       = '0;
    wr_seg.mode  = WrMode;
    wr_seg.steps = STEP_W_MAX'(WrSteps);
  end

  step_seq_table #(
    .NUM_SEG (NUM_SEG),
    .SEG_W   (SEG_W)
  ) u_table (
    .CLK     (CLK),
    .wr_en   (table_wr_en),
    .wr_addr (WrAddr),
    .wr_data (wr_seg),
    .rd_addr (seg_idx_reg),
    .rd_data (rd_seg)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      seg_idx_reg    <= '0;
      step_count_reg <= '0;
      target_reg     <= '0;
      mode_reg       <= MODE_SLOW;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pulse_q_reg    <= 1'b0;
      gap_cnt_reg    <= '0;
    end else if (Abort) begin
      // Index, count and mode are left untouched for post-mortem inspection.
      state_reg <= ST_IDLE;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Go) begin
            state_reg   <= ST_FETCH;
            seg_idx_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (rd_seg.steps == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg      <= ST_RUN;
            target_reg     <= rd_seg.steps[STEP_W-1:0];
            mode_reg       <= rd_seg.mode;
            step_count_reg <= '0;
            pulse_q_reg    <= 1'b0;
            start_reg      <= 1'b1;
          end
        end

        ST_RUN: begin
          pulse_q_reg <= Pulse;
          if (pulse_rise) begin
            step_count_reg <= step_count_next;
            if (step_count_next == target_reg) begin
              state_reg   <= ST_GAP;
              start_reg   <= 1'b0;
              gap_cnt_reg <= '0;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            if (seg_idx_reg == SEG_W'(NUM_SEG - 1)) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_FETCH;
              seg_idx_reg <= seg_idx_reg + SEG_W'(1);
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          start_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Start     = start_reg;
  assign Mode      = mode_reg;
  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign SegIdx    = seg_idx_reg;
  assign StepCount = step_count_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer: programs the table, plays
// segments with hand-driven Pulse edges and checks against hand-computed values.
module tb_step_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WrEn = 1'b0;
  logic [2:0]  WrAddr = '0;
  logic [1:0]  WrMode = '0;
  logic [15:0] WrSteps = '0;
  logic        Go = 1'b0;
  logic        Abort = 1'b0;
  logic        Pulse = 1'b0;
  logic        Start;
  logic [1:0]  Mode;
  logic        Busy;
  logic        Done;
  logic [2:0]  SegIdx;
  logic [15:0] StepCount;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  step_sequencer #(
    .NUM_SEG    (8),
    .STEP_W     (16),
    .GAP_CYCLES (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrMode    (WrMode),
    .WrSteps   (WrSteps),
    .Go        (Go),
    .Abort     (Abort),
    .Pulse     (Pulse),
    .Start     (Start),
    .Mode      (Mode),
    .Busy      (Busy),
    .Done      (Done),
    .SegIdx    (SegIdx),
    .StepCount (StepCount)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (Done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [15:0] s);
    WrEn = 1'b1; WrAddr = a; WrMode = m; WrSteps = s;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic pulse();
    Pulse = 1'b1; tick();
    Pulse = 1'b0; tick();
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (Start !== 1'b1 && n < 50) begin tick(); n++; end
    check(tag, 32'(Start), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (Done !== 1'b1 && cycles < 50) begin tick(); cycles++; end
    check(tag, 32'(Done), 32'd1);
  endtask

  initial begin
    int lows;
    int cyc;
    int d0;

    // Reset state
    tick(); tick();
    check("rst_start", 32'(Start), 0);
    check("rst_mode", 32'(Mode), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_segidx", 32'(SegIdx), 0);
    check("rst_stepcount", 32'(StepCount), 0);
    RESET = 1'b0;
    tick();

    // Three-segment program {00,3},{01,5},{10,0}
    wr(3'd0, 2'b00, 16'd3);
    wr(3'd1, 2'b01, 16'd5);
    wr(3'd2, 2'b10, 16'd0);
    done_cnt = 0;
    Go = 1'b1; tick(); Go = 1'b0;
    check("p1_fetch_start", 32'(Start), 0);
    check("p1_fetch_busy", 32'(Busy), 1);
    tick();
    check("p1_run_start", 32'(Start), 1);
    check("p1_run_mode", 32'(Mode), 0);
    pulse(); pulse();
    check("p1_cnt2", 32'(StepCount), 2);
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("p1_seg0_cnt", 32'(StepCount), 3);
    check("p1_seg0_stop", 32'(Start), 0);
    lows = 1;
    while (Start !== 1'b1 && lows < 20) begin tick(); if (Start !== 1'b1) lows++; end
    check("p1_gap_low", 32'(lows), 3);
    check("p1_seg1_mode", 32'(Mode), 1);
    check("p1_seg1_idx", 32'(SegIdx), 1);
    check("p1_seg1_cnt0", 32'(StepCount), 0);
    pulse(); pulse(); pulse(); pulse();
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("p1_seg1_cnt", 32'(StepCount), 5);
    check("p1_seg1_stop", 32'(Start), 0);
    wait_done("p1_done", cyc);
    check("p1_done_lat", 32'(cyc), 3);
    check("p1_done_idx", 32'(SegIdx), 2);
    check("p1_done_mode", 32'(Mode), 1);
    tick();
    check("p1_idle_busy", 32'(Busy), 0);
    check("p1_idle_done", 32'(Done), 0);
    tick();
    check("p1_done_count", 32'(done_cnt), 1);

    // Full table of {10,2}
    for (int i = 0; i < 8; i++) wr(3'(i), 2'b10, 16'd2);
    done_cnt = 0;
    Go = 1'b1; tick(); Go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_start("p2_start");
      check("p2_segidx", 32'(SegIdx), 32'(i));
      check("p2_mode", 32'(Mode), 2);
      pulse(); pulse();
    end
    wait_done("p2_done", cyc);
    check("p2_done_idx", 32'(SegIdx), 7);
    check("p2_done_cnt", 32'(StepCount), 2);
    tick(); tick();
    check("p2_done_count", 32'(done_cnt), 1);

    // Terminator at entry 0, written in the same cycle as Go
    done_cnt = 0;
    WrEn = 1'b1; WrAddr = 3'd0; WrMode = 2'b00; WrSteps = 16'd0; Go = 1'b1;
    tick();
    WrEn = 1'b0; Go = 1'b0;
    check("term_fetch_start", 32'(Start), 0);
    check("term_fetch_done", 32'(Done), 0);
    tick();
    check("term_done", 32'(Done), 1);
    check("term_start", 32'(Start), 0);
    tick();
    check("term_idle_busy", 32'(Busy), 0);
    check("term_idle_done", 32'(Done), 0);
    check("term_done_count", 32'(done_cnt), 1);

    // Go and Abort together: stays idle
    Go = 1'b1; Abort = 1'b1; tick(); Go = 1'b0; Abort = 1'b0;
    check("goabort_busy", 32'(Busy), 0);

    // Abort during RUN after 4 edges
    wr(3'd0, 2'b00, 16'd10);
    done_cnt = 0;
    Go = 1'b1; tick(); Go = 1'b0;
    wait_start("ab_start");
    pulse(); pulse(); pulse(); pulse();
    Abort = 1'b1; tick(); Abort = 1'b0;
    check("ab_start_low", 32'(Start), 0);
    check("ab_busy_low", 32'(Busy), 0);
    check("ab_cnt", 32'(StepCount), 4);
    pulse(); pulse();
    check("ab_cnt_hold", 32'(StepCount), 4);
    check("ab_no_done", 32'(done_cnt), 0);

    // Go and WrEn while busy must be ignored
    wr(3'd0, 2'b01, 16'd3);
    wr(3'd1, 2'b11, 16'd2);
    wr(3'd2, 2'b00, 16'd0);
    Go = 1'b1; tick(); Go = 1'b0;
    wait_start("busy_start");
    pulse();
    Go = 1'b1; WrEn = 1'b1; WrAddr = 3'd1; WrMode = 2'b00; WrSteps = 16'd7;
    tick();
    Go = 1'b0; WrEn = 1'b0;
    check("busy_idx", 32'(SegIdx), 0);
    check("busy_run", 32'(Start), 1);
    pulse(); pulse();
    check("busy_seg0_cnt", 32'(StepCount), 3);
    wait_start("busy_seg1_start");
    check("busy_seg1_mode", 32'(Mode), 3);
    pulse();
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("busy_seg1_stop", 32'(Start), 0);
    wait_done("busy_done", cyc);
    tick();

    // Readback by replay: entry 1 must still be {11,2}
    Go = 1'b1; tick(); Go = 1'b0;
    wait_start("rb_start");
    pulse(); pulse(); pulse();
    wait_start("rb_seg1_start");
    check("rb_seg1_mode", 32'(Mode), 3);
    pulse();
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("rb_seg1_cnt", 32'(StepCount), 2);
    check("rb_seg1_stop", 32'(Start), 0);
    wait_done("rb_done", cyc);
    tick();

    // RESET mid-RUN, then replay from the retained table
    Go = 1'b1; tick(); Go = 1'b0;
    wait_start("mr_start");
    pulse(); pulse(); pulse();
    wait_start("mr_seg1_start");
    pulse();
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("mr_start_rst", 32'(Start), 0);
    check("mr_mode_rst", 32'(Mode), 0);
    check("mr_busy_rst", 32'(Busy), 0);
    check("mr_done_rst", 32'(Done), 0);
    check("mr_idx_rst", 32'(SegIdx), 0);
    check("mr_cnt_rst", 32'(StepCount), 0);
    d0 = done_cnt;
    Go = 1'b1; tick(); Go = 1'b0;
    wait_start("mr_replay_start");
    check("mr_replay_mode", 32'(Mode), 1);
    pulse(); pulse();
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("mr_replay_cnt", 32'(StepCount), 3);
    check("mr_replay_stop", 32'(Start), 0);
    wait_start("mr_replay_seg1");
    check("mr_replay_seg1_mode", 32'(Mode), 3);
    pulse(); pulse();
    wait_done("mr_replay_done", cyc);
    tick();
    check("mr_replay_done_count", 32'(done_cnt - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
